// File: rtl/nubus_pkg.sv
// nubus_pkg: shared state type and constants for the NuBus slot bridge.
package nubus_pkg;
  typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;
  localparam logic [3:0] SLOT_SPACE = 4'hF;
  localparam int TIMEOUT_W = 8;
endpackage

// File: rtl/nubus_slot_bridge.sv
// nubus_slot_bridge: 68k bus to NuBus slot card bridge with select/ack handshake and IRQ forwarding.
module nubus_slot_bridge
  import nubus_pkg::*;
#(
  parameter logic [3:0] SLOT_ID = 4'h9,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] cpu_addr,
  input  logic [15:0] cpu_data_in,
  output logic [15:0] cpu_data_out,
  input  logic        cpu_as_n,
  input  logic        cpu_uds_n,
  input  logic        cpu_lds_n,
  input  logic        cpu_rw,
  output logic        cpu_dtack_n,
  output logic        cpu_berr_n,
  output logic        slot_hit,
  output logic [31:0] slot_addr,
  output logic [15:0] slot_wdata,
  input  logic [15:0] slot_rdata,
  output logic [1:0]  slot_uds_lds,
  output logic        slot_rw_n,
  output logic        slot_select,
  input  logic        slot_ack_n,
  input  logic        slot_nmrq_n,
  output logic        slot_irq_n
);
  state_t state;
  logic start;
  assign slot_hit = cpu_addr[31:24] == {SLOT_SPACE, SLOT_ID};
  assign start = !cpu_as_n && (!cpu_uds_n || !cpu_lds_n) && slot_hit && slot_ack_n;
`ifdef NUBUS_TIMEOUT_EN
  localparam int CW = TIMEOUT_CYCLES > 255 ? 16 : TIMEOUT_W;
  logic [CW-1:0] tcnt;
  logic berr_n, tmo;
  assign tmo = state == REQ && slot_ack_n && tcnt == CW'(TIMEOUT_CYCLES - 1);
  assign cpu_berr_n = berr_n;
  always_ff @(posedge clk)
    if (!reset_n || state != REQ) tcnt <= '0;
    else tcnt <= tcnt + 1'b1;
  always_ff @(posedge clk)
    if (!reset_n) berr_n <= 1'b1;
    else if (tmo) berr_n <= 1'b0;
    else if (state == ERR && cpu_as_n) berr_n <= 1'b1;
`else
  assign cpu_berr_n = 1'b1;
`endif
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= IDLE;
      cpu_dtack_n  <= 1'b1;
      slot_select  <= 1'b0;
      slot_irq_n   <= 1'b1;
      cpu_data_out <= '0;
      slot_addr    <= '0;
      slot_wdata   <= '0;
      slot_uds_lds <= '0;
      slot_rw_n    <= 1'b1;
    end else begin
      slot_irq_n <= slot_nmrq_n;
      case (state)
        IDLE: if (start) begin
          slot_addr    <= cpu_addr;
          slot_wdata   <= cpu_data_in;
          slot_uds_lds <= {~cpu_uds_n, ~cpu_lds_n};
          slot_rw_n    <= cpu_rw;
          slot_select  <= 1'b1;
          state        <= REQ;
        end
        REQ: if (!slot_ack_n) begin
          if (slot_rw_n) cpu_data_out <= slot_rdata;
          cpu_dtack_n <= 1'b0;
          slot_select <= 1'b0;
          state       <= DONE;
        end
`ifdef NUBUS_TIMEOUT_EN
        else if (tmo) begin
          slot_select <= 1'b0;
          state       <= ERR;
        end
        ERR: if (cpu_as_n) state <= IDLE;
`endif
        DONE: if (cpu_as_n) begin
          cpu_dtack_n <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_nubus_slot_bridge.sv
// tb_nubus_slot_bridge: randomized scoreboard bench with a stub NuBus card.
module tb_nubus_slot_bridge;
  logic clk = 0, reset_n = 0;
  logic [31:0] cpu_addr = 0;
  logic [15:0] cpu_data_in = 0, cpu_data_out;
  logic cpu_as_n = 1, cpu_uds_n = 1, cpu_lds_n = 1, cpu_rw = 1;
  logic cpu_dtack_n, cpu_berr_n, slot_hit;
  logic [31:0] slot_addr;
  logic [15:0] slot_wdata, slot_rdata;
  logic [1:0] slot_uds_lds;
  logic slot_rw_n, slot_select, slot_irq_n;
  logic slot_ack_n = 1, slot_nmrq_n = 1;
  always #5 clk = ~clk;

  nubus_slot_bridge #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset_n(reset_n), .cpu_addr(cpu_addr), .cpu_data_in(cpu_data_in),
    .cpu_data_out(cpu_data_out), .cpu_as_n(cpu_as_n), .cpu_uds_n(cpu_uds_n),
    .cpu_lds_n(cpu_lds_n), .cpu_rw(cpu_rw), .cpu_dtack_n(cpu_dtack_n),
    .cpu_berr_n(cpu_berr_n), .slot_hit(slot_hit), .slot_addr(slot_addr),
    .slot_wdata(slot_wdata), .slot_rdata(slot_rdata), .slot_uds_lds(slot_uds_lds),
    .slot_rw_n(slot_rw_n), .slot_select(slot_select), .slot_ack_n(slot_ack_n),
    .slot_nmrq_n(slot_nmrq_n), .slot_irq_n(slot_irq_n)
  );

  int checks = 0, failures = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  int ack_delay = 1, ccnt = 0;
  logic hold_ack = 0;
  logic [15:0] card_data = 0;
  assign slot_rdata = card_data;
  always @(posedge clk) begin
    if (!reset_n) begin
      ccnt <= 0;
      slot_ack_n <= 1'b1;
    end else if (slot_select) begin
      ccnt <= ccnt + 1;
      slot_ack_n <= !(ccnt + 1 >= ack_delay);
    end else begin
      ccnt <= 0;
      if (!hold_ack) slot_ack_n <= 1'b1;
    end
  end

  typedef struct packed {
    logic [31:0] a;
    logic [15:0] d;
    logic [1:0]  ul;
    logic        rw;
  } req_t;
  req_t exp_req[$];
  logic [15:0] exp_rsp[$];
  logic [15:0] last_rd = 0;

  logic sel_q = 0, dt_q = 1, nm_q = 1, rs_q = 0;
  int sel_rises = 0;
  req_t r;
  logic [15:0] rsp;
  always @(posedge clk) begin
    nm_q <= slot_nmrq_n;
    rs_q <= reset_n;
  end
  always @(negedge clk) begin
    if (slot_select && !sel_q) begin
      sel_rises++;
      if (exp_req.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_select: got select with empty queue required none");
      end else begin
        r = exp_req.pop_front();
        chk("slot_addr", slot_addr, r.a);
        chk("slot_wdata", {16'h0, slot_wdata}, {16'h0, r.d});
        chk("slot_uds_lds", {30'h0, slot_uds_lds}, {30'h0, r.ul});
        chk("slot_rw_n", {31'h0, slot_rw_n}, {31'h0, r.rw});
      end
    end
    if (!cpu_dtack_n && dt_q) begin
      if (exp_rsp.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_dtack: got dtack with empty queue required none");
      end else begin
        rsp = exp_rsp.pop_front();
        chk("cpu_data_out", {16'h0, cpu_data_out}, {16'h0, rsp});
      end
    end
    sel_q = slot_select;
    dt_q = cpu_dtack_n;
    chk("slot_irq_n", {31'h0, slot_irq_n}, rs_q ? {31'h0, nm_q} : 32'h1);
  end

  task automatic release_cpu();
    cpu_as_n = 1; cpu_uds_n = 1; cpu_lds_n = 1;
  endtask

  task automatic txn(input logic [31:0] a, input logic [15:0] d, input logic [1:0] ul,
                     input logic rw, input logic [15:0] rd, input int dly, input bit early,
                     input int defer);
    int n, s0;
    logic [15:0] e;
    card_data = rd;
    ack_delay = dly;
    e = rw ? rd : last_rd;
    if (rw) last_rd = rd;
    exp_req.push_back('{a: a, d: d, ul: ul, rw: rw});
    exp_rsp.push_back(e);
    s0 = sel_rises;
    cpu_addr = a; cpu_data_in = d; cpu_rw = rw;
    cpu_uds_n = !ul[1]; cpu_lds_n = !ul[0]; cpu_as_n = 0;
    slot_nmrq_n = 1'($urandom);
    #1 chk("slot_hit", {31'h0, slot_hit}, 32'h1);
    for (int i = 0; i < defer; i++) begin
      @(posedge clk); @(negedge clk);
      chk("defer_no_select", {31'h0, slot_select}, 32'h0);
    end
    if (defer > 0) hold_ack = 0;
    n = 0;
    do begin
      @(posedge clk); n++; @(negedge clk);
      if (early && n == 1) release_cpu();
    end while (cpu_dtack_n && n < 60);
    chk("dtack_latency", n, dly + 2 + ((defer > 0) ? 1 : 0));
    if (!early) repeat ($urandom_range(3)) begin
      @(posedge clk); @(negedge clk);
      chk("dtack_hold", {31'h0, cpu_dtack_n}, 32'h0);
      chk("data_hold", {16'h0, cpu_data_out}, {16'h0, e});
    end
    release_cpu();
    @(posedge clk); @(negedge clk);
    chk("dtack_release", {31'h0, cpu_dtack_n}, 32'h1);
    chk("select_pulses", sel_rises - s0, 1);
  endtask

  task automatic outside(input logic [31:0] a);
    bit bad;
    bad = 0;
    cpu_addr = a; cpu_rw = 1; cpu_as_n = 0; cpu_uds_n = 0; cpu_lds_n = 0;
    #1 chk("outside_hit", {31'h0, slot_hit}, 32'h0);
    repeat (20) begin
      @(posedge clk); @(negedge clk);
      if (slot_hit || slot_select || !cpu_dtack_n) bad = 1;
    end
    chk("outside_quiet", {31'h0, bad}, 32'h0);
    release_cpu();
    @(negedge clk);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_dtack", {31'h0, cpu_dtack_n}, 32'h1);
    chk("rst_berr", {31'h0, cpu_berr_n}, 32'h1);
    chk("rst_select", {31'h0, slot_select}, 32'h0);
    chk("rst_irq", {31'h0, slot_irq_n}, 32'h1);
    chk("rst_data_out", {16'h0, cpu_data_out}, 32'h0);
    chk("rst_addr", slot_addr, 32'h0);
    chk("rst_wdata", {16'h0, slot_wdata}, 32'h0);
    chk("rst_uds_lds", {30'h0, slot_uds_lds}, 32'h0);
    chk("rst_rw_n", {31'h0, slot_rw_n}, 32'h1);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk_reset_outputs();
    reset_n = 1;
    @(negedge clk);
    txn(32'hF900_0000, 16'h0000, 2'b11, 1'b1, 16'hA55A, 1, 0, 0);
    txn(32'hF908_0018, 16'h7F00, 2'b10, 1'b0, 16'h1234, 1, 0, 0);
    chk("write_keeps_data", {16'h0, cpu_data_out}, 32'hA55A);
    outside(32'hF800_0000);
    outside(32'hFA00_0000);
    hold_ack = 1;
    txn(32'hF900_0100, 16'h0000, 2'b11, 1'b1, 16'h0F0F, 2, 0, 0);
    txn(32'hF900_0102, 16'h4321, 2'b01, 1'b0, 16'h0000, 1, 0, 5);
    txn(32'hF900_0200, 16'h0000, 2'b11, 1'b1, 16'hC3C3, 4, 1, 0);
    repeat (25)
      txn({8'hF9, 24'($urandom)}, 16'($urandom), 2'($urandom_range(1, 3)), 1'($urandom),
          16'($urandom), $urandom_range(1, 4), ($urandom_range(3) == 0), 0);
`ifdef NUBUS_TIMEOUT_EN
    ack_delay = 1000;
    exp_req.push_back('{a: 32'hF900_0040, d: 16'h0, ul: 2'b11, rw: 1'b1});
    cpu_addr = 32'hF900_0040; cpu_data_in = 0; cpu_rw = 1;
    cpu_as_n = 0; cpu_uds_n = 0; cpu_lds_n = 0;
    n = 0;
    do begin @(posedge clk); n++; @(negedge clk); end while (cpu_berr_n && n < 60);
    chk("berr_latency", n, 17);
    chk("berr_select", {31'h0, slot_select}, 32'h0);
    chk("berr_no_dtack", {31'h0, cpu_dtack_n}, 32'h1);
    @(posedge clk); @(negedge clk);
    chk("berr_hold", {31'h0, cpu_berr_n}, 32'h0);
    release_cpu();
    @(posedge clk); @(negedge clk);
    chk("berr_release", {31'h0, cpu_berr_n}, 32'h1);
    txn(32'hF900_0042, 16'h0000, 2'b11, 1'b1, 16'hBEEF, 15, 0, 0);
`endif
    ack_delay = 1000;
    exp_req.push_back('{a: 32'hF900_4444, d: 16'h5555, ul: 2'b01, rw: 1'b0});
    cpu_addr = 32'hF900_4444; cpu_data_in = 16'h5555; cpu_rw = 0;
    cpu_as_n = 0; cpu_uds_n = 1; cpu_lds_n = 0;
    n = 0;
    do begin @(negedge clk); n++; end while (!slot_select && n < 10);
    chk("rst_select_seen", {31'h0, slot_select}, 32'h1);
    reset_n = 0;
    slot_nmrq_n = 0;
    @(posedge clk); @(negedge clk);
    chk_reset_outputs();
    release_cpu();
    reset_n = 1;
    last_rd = 0;
    @(posedge clk); @(negedge clk);
    chk("irq_after_reset", {31'h0, slot_irq_n}, 32'h0);
    chk("no_dtack_after_abort", {31'h0, cpu_dtack_n}, 32'h1);
    chk("scoreboard_drained", exp_req.size() + exp_rsp.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test required finish before time limit");
    $fatal(1, "watchdog");
  end
endmodule
